mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer that lets the CORE's instruction-fetch port and data port share one single-port synchronous memory (1-cycle read latency, byte enables). It sits between CORE and a unified INS/DATA memory and replaces the separate INS_MEM and DATAMEM instances in a single-RAM build. It serialises accesses, stalls the losing requester and routes read data back to the owner.

## Interface

Parameters:
- DATAWIDTH, 32, data bus width
- ADDR_WIDTH, 10, memory word-address width
- STARVE_LIMIT, 4, consecutive instruction denials before the instruction port is forced to win (1..15)

Ports:
- MEMARB_Clk_in  in  1  single clock, all state on rising edge
- MEMARB_Reset_in  in  1  synchronous, active-high reset
- MEMARB_Ins_Read_in  in  1  instruction-fetch request, held until accepted
- MEMARB_Ins_Addr_InBUS  in  ADDR_WIDTH  fetch address
- MEMARB_Ins_Wait_out  out  1  request not accepted this cycle
- MEMARB_Ins_Valid_out  out  1  fetch data valid, one-cycle pulse
- MEMARB_Ins_Readdata_OutBUS  out  DATAWIDTH  fetch data, held until the next valid
- MEMARB_Data_Read_in  in  1  data read request
- MEMARB_Data_Write_in  in  1  data write request
- MEMARB_Data_Byteenable_InBUS  in  4  write byte enables
- MEMARB_Data_Addr_InBUS  in  ADDR_WIDTH  data address
- MEMARB_Data_Writedata_InBUS  in  DATAWIDTH  write data
- MEMARB_Data_Wait_out  out  1  request not accepted this cycle
- MEMARB_Data_Valid_out  out  1  read data valid, one-cycle pulse
- MEMARB_Data_Readdata_OutBUS  out  DATAWIDTH  read data, held until the next valid
- MEMARB_Mem_Re_out / MEMARB_Mem_We_out  out  1  memory read / write strobe
- MEMARB_Mem_Byteenable_OutBUS  out  4  forwarded byte enables (4'b1111 on reads)
- MEMARB_Mem_Addr_OutBUS  out  ADDR_WIDTH  memory address
- MEMARB_Mem_Writedata_OutBUS  out  DATAWIDTH  memory write data
- MEMARB_Mem_Readdata_InBUS  in  DATAWIDTH  memory read data, valid one cycle after Re

## Operation

- At most one access is issued per cycle. A request is accepted in a cycle where it is asserted and its Wait is low. The requester holds the request and its operands until acceptance.
- Priority is data over instruction. When the starvation counter equals STARVE_LIMIT, the instruction port wins instead.
- Starvation counter (4 bits): increments when the instruction port requests and loses, clears when it is granted or idle. It saturates at STARVE_LIMIT.
- Data read and write asserted together: the write is issued and the read is ignored. The read stays pending, so Data_Wait is high.
- Read response tracking: a registered tag, one of TAG_NONE, TAG_INS or TAG_DATA, records the owner of the read issued last cycle. Next cycle, Mem_Readdata_InBUS is captured into that owner's Readdata register and its Valid pulses.
- A new access may be issued in the same cycle a response returns, giving back-to-back throughput.
- Writes produce no response. They are complete at the accepting edge.

## Timing

- Grant, Wait and all Mem_* outputs are combinational from the requests, the counter and reset. Latency from request to Mem strobe is 0 cycles.
- Read latency: Valid and Readdata are registered, asserted 1 cycle after acceptance.
- During reset:
  - Wait outputs are forced high.
  - Mem_Re and Mem_We are forced 0, and Mem address, data and byte enables are driven 0.
- Register reset values: tag TAG_NONE, counter 0, both Valid 0, both Readdata 0.
- Reset asserted while a read is in flight: the response is discarded and no Valid is asserted after reset.
- No request asserted: all Mem strobes are 0, both Wait outputs are low, and the tag goes to TAG_NONE.

## Configuration

- MEMARB_STARVE_GUARD_EN defined: the starvation counter and forced-instruction grant are present as described above.
- MEMARB_STARVE_GUARD_EN undefined: strict data priority, no counter, and STARVE_LIMIT is ignored.

## Structure

- Package mem_arbiter_pkg holds:
  - the 2-bit tag encoding TAG_NONE = 0, TAG_INS = 1, TAG_DATA = 2
  - the grant encoding GNT_NONE / GNT_INS / GNT_DATA_RD / GNT_DATA_WR
- One sub-module, mem_arbiter_prio:
  - contains the combinational grant decision plus the starvation counter
  - is the only part affected by the macro
- The top level contains the tag register, the response routing and the Mem_* output mux.

## Test plan

- Instruction-only fetch of addr 0x004, memory returns 0x00500093 → Mem_Re with addr 0x004 in cycle 0, Ins_Valid and Readdata 0x00500093 in cycle 1, Ins_Wait never high.
- Simultaneous fetch 0x010 and data read 0x020 → data granted first with Ins_Wait high. Fetch issued the next cycle, both Valid pulses land on the correct ports one cycle apart.
- Data write to 0x030, data 0xDEADBEEF, byte enables 4'b0011 → Mem_We for one cycle with byte enables 0011 forwarded, no Data_Valid.
- Data port requesting continuously, STARVE_LIMIT = 4, guard enabled → the instruction fetch is granted on the 5th contended cycle. With the guard disabled, it is never granted.
- Reset asserted in the cycle after a data read is accepted → no Data_Valid, Readdata 0, Waits high during reset.
- Data read and write asserted together → write issued first and read issued the next cycle, Data_Wait high for exactly 1 cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
//
// tag_e   : owner of the read issued in the previous cycle (TAG_NONE/TAG_INS/TAG_DATA).
// grant_e : access issued to the memory this cycle.
// grant_to_tag() maps an issued access onto the response tag it creates.
package mem_arbiter_pkg;

    localparam int unsigned BE_WIDTH  = 4;
    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_INS  = 2'd1,
        TAG_DATA = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_INS     = 2'd1,
        GNT_DATA_RD = 2'd2,
        GNT_DATA_WR = 2'd3
    } grant_e;

    // Writes produce no response, so only reads leave a tag behind.
    function automatic tag_e grant_to_tag(input grant_e grant);
        tag_e tag;
        unique case (grant)
            GNT_INS:     tag = TAG_INS;
            GNT_DATA_RD: tag = TAG_DATA;
            default:     tag = TAG_NONE;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// Grant decision for the shared memory port.
//
// Data beats instruction, and a data write beats a data read. When the optional starvation guard
// is built in (macro MEMARB_STARVE_GUARD_EN), a 4-bit counter of consecutive instruction denials
// forces an instruction grant once it reaches STARVE_LIMIT. Without the macro the priority is
// strictly data first and STARVE_LIMIT has no effect.
//
// Ports:
//   clk      clock, counter updates on the rising edge
//   reset    synchronous active-high reset; also suppresses any grant
//   ins_req  instruction-fetch request
//   data_rd  data read request
//   data_wr  data write request
//   grant    access issued this cycle (combinational)
module mem_arbiter_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ins_req,
    input  logic   data_rd,
    input  logic   data_wr,
    output grant_e grant
);

    logic force_ins;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_cnt;

    assign force_ins = ins_req && (starve_cnt == LIMIT);

    // Counts denied fetches; once at LIMIT the fetch wins, which clears it again.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (ins_req && (grant != GNT_INS)) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_WIDTH'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    logic unused_guard;

    assign force_ins    = 1'b0;
    assign unused_guard = ^{clk, CNT_WIDTH'(STARVE_LIMIT)};
`endif

    always_comb begin
        grant = GNT_NONE;
        if (reset) begin
            grant = GNT_NONE;
        end else if (force_ins) begin
            grant = GNT_INS;
        end else if (data_wr) begin
            grant = GNT_DATA_WR;
        end else if (data_rd) begin
            grant = GNT_DATA_RD;
        end else if (ins_req) begin
            grant = GNT_INS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port synchronous memory (1-cycle read latency) between
// the core's instruction-fetch port and data port.
//
// Optional feature: define MEMARB_STARVE_GUARD_EN to enable the instruction starvation guard.
//
// Ports:
//   MEMARB_Clk_in, MEMARB_Reset_in          clock, synchronous active-high reset
//   MEMARB_Ins_*                            fetch request/address in; wait, valid, read data out
//   MEMARB_Data_*                           data read/write request, byte enables, address,
//                                           write data in; wait, valid, read data out
//   MEMARB_Mem_*                            memory strobes, byte enables, address, write data
//                                           out; memory read data in (one cycle after Re)
//
// Grant, waits and memory outputs are combinational. A read's owner is held in a registered tag;
// in the following cycle that owner's Valid is high and its read data port passes the memory
// data through, which is also captured so the port holds it until the next response.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  MEMARB_Clk_in,
    input  logic                  MEMARB_Reset_in,

    input  logic                  MEMARB_Ins_Read_in,
    input  logic [ADDR_WIDTH-1:0] MEMARB_Ins_Addr_InBUS,
    output logic                  MEMARB_Ins_Wait_out,
    output logic                  MEMARB_Ins_Valid_out,
    output logic [DATAWIDTH-1:0]  MEMARB_Ins_Readdata_OutBUS,

    input  logic                  MEMARB_Data_Read_in,
    input  logic                  MEMARB_Data_Write_in,
    input  logic [BE_WIDTH-1:0]   MEMARB_Data_Byteenable_InBUS,
    input  logic [ADDR_WIDTH-1:0] MEMARB_Data_Addr_InBUS,
    input  logic [DATAWIDTH-1:0]  MEMARB_Data_Writedata_InBUS,
    output logic                  MEMARB_Data_Wait_out,
    output logic                  MEMARB_Data_Valid_out,
    output logic [DATAWIDTH-1:0]  MEMARB_Data_Readdata_OutBUS,

    output logic                  MEMARB_Mem_Re_out,
    output logic                  MEMARB_Mem_We_out,
    output logic [BE_WIDTH-1:0]   MEMARB_Mem_Byteenable_OutBUS,
    output logic [ADDR_WIDTH-1:0] MEMARB_Mem_Addr_OutBUS,
    output logic [DATAWIDTH-1:0]  MEMARB_Mem_Writedata_OutBUS,
    input  logic [DATAWIDTH-1:0]  MEMARB_Mem_Readdata_InBUS
);

    grant_e               grant;
    tag_e                 tag;
    logic [DATAWIDTH-1:0] ins_hold;
    logic [DATAWIDTH-1:0] data_hold;

    mem_arbiter_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk     (MEMARB_Clk_in),
        .reset   (MEMARB_Reset_in),
        .ins_req (MEMARB_Ins_Read_in),
        .data_rd (MEMARB_Data_Read_in),
        .data_wr (MEMARB_Data_Write_in),
        .grant   (grant)
    );

    // With read and write both asserted the write is issued and the read term keeps Wait high.
    assign MEMARB_Ins_Wait_out  = MEMARB_Reset_in
                                | (MEMARB_Ins_Read_in && (grant != GNT_INS));
    assign MEMARB_Data_Wait_out = MEMARB_Reset_in
                                | (MEMARB_Data_Read_in && (grant != GNT_DATA_RD))
                                | (MEMARB_Data_Write_in && (grant != GNT_DATA_WR));

    always_comb begin
        MEMARB_Mem_Re_out            = 1'b0;
        MEMARB_Mem_We_out            = 1'b0;
        MEMARB_Mem_Byteenable_OutBUS = '0;
        MEMARB_Mem_Addr_OutBUS       = '0;
        MEMARB_Mem_Writedata_OutBUS  = '0;
        unique case (grant)
            GNT_INS: begin
                MEMARB_Mem_Re_out            = 1'b1;
                MEMARB_Mem_Byteenable_OutBUS = '1;
                MEMARB_Mem_Addr_OutBUS       = MEMARB_Ins_Addr_InBUS;
            end
            GNT_DATA_RD: begin
                MEMARB_Mem_Re_out            = 1'b1;
                MEMARB_Mem_Byteenable_OutBUS = '1;
                MEMARB_Mem_Addr_OutBUS       = MEMARB_Data_Addr_InBUS;
            end
            GNT_DATA_WR: begin
                MEMARB_Mem_We_out            = 1'b1;
                MEMARB_Mem_Byteenable_OutBUS = MEMARB_Data_Byteenable_InBUS;
                MEMARB_Mem_Addr_OutBUS       = MEMARB_Data_Addr_InBUS;
                MEMARB_Mem_Writedata_OutBUS  = MEMARB_Data_Writedata_InBUS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge MEMARB_Clk_in) begin
        if (MEMARB_Reset_in) begin
            tag       <= TAG_NONE;
            ins_hold  <= '0;
            data_hold <= '0;
        end else begin
            tag <= grant_to_tag(grant);
            if (tag == TAG_INS) begin
                ins_hold <= MEMARB_Mem_Readdata_InBUS;
            end
            if (tag == TAG_DATA) begin
                data_hold <= MEMARB_Mem_Readdata_InBUS;
            end
        end
    end

    // Reset masks a response still in flight from the cycle before reset was raised.
    assign MEMARB_Ins_Valid_out  = !MEMARB_Reset_in && (tag == TAG_INS);
    assign MEMARB_Data_Valid_out = !MEMARB_Reset_in && (tag == TAG_DATA);

    assign MEMARB_Ins_Readdata_OutBUS  = MEMARB_Reset_in      ? '0 :
                                         MEMARB_Ins_Valid_out ? MEMARB_Mem_Readdata_InBUS :
                                                                ins_hold;
    assign MEMARB_Data_Readdata_OutBUS = MEMARB_Reset_in       ? '0 :
                                         MEMARB_Data_Valid_out ? MEMARB_Mem_Readdata_InBUS :
                                                                 data_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs are driven 1 time unit after each rising edge and
// outputs are sampled 1 unit later, well clear of the next edge.
module tb_mem_arbiter;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ins_read;
    logic [9:0]  ins_addr;
    logic        ins_wait;
    logic        ins_valid;
    logic [31:0] ins_rdata;
    logic        data_rd;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [9:0]  data_addr;
    logic [31:0] data_wdata;
    logic        data_wait;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .DATAWIDTH    (32),
        .ADDR_WIDTH   (10),
        .STARVE_LIMIT (4)
    ) dut (
        .MEMARB_Clk_in                (clk),
        .MEMARB_Reset_in              (reset),
        .MEMARB_Ins_Read_in           (ins_read),
        .MEMARB_Ins_Addr_InBUS        (ins_addr),
        .MEMARB_Ins_Wait_out          (ins_wait),
        .MEMARB_Ins_Valid_out         (ins_valid),
        .MEMARB_Ins_Readdata_OutBUS   (ins_rdata),
        .MEMARB_Data_Read_in          (data_rd),
        .MEMARB_Data_Write_in         (data_wr),
        .MEMARB_Data_Byteenable_InBUS (data_be),
        .MEMARB_Data_Addr_InBUS       (data_addr),
        .MEMARB_Data_Writedata_InBUS  (data_wdata),
        .MEMARB_Data_Wait_out         (data_wait),
        .MEMARB_Data_Valid_out        (data_valid),
        .MEMARB_Data_Readdata_OutBUS  (data_rdata),
        .MEMARB_Mem_Re_out            (mem_re),
        .MEMARB_Mem_We_out            (mem_we),
        .MEMARB_Mem_Byteenable_OutBUS (mem_be),
        .MEMARB_Mem_Addr_OutBUS       (mem_addr),
        .MEMARB_Mem_Writedata_OutBUS  (mem_wdata),
        .MEMARB_Mem_Readdata_InBUS    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ins_read = 1'b0;
        data_rd  = 1'b0;
        data_wr  = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        ins_read   = 1'b1;
        ins_addr   = 10'h005;
        data_rd    = 1'b0;
        data_wr    = 1'b1;
        data_be    = 4'b1111;
        data_addr  = 10'h030;
        data_wdata = 32'hFFFF_FFFF;
        mem_rdata  = 32'h0;

        // Reset with requests asserted: everything quiet, waits high.
        tick();
        settle();
        check("rst_ins_wait", ins_wait, 1);
        check("rst_data_wait", data_wait, 1);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_ins_valid", ins_valid, 0);
        check("rst_data_valid", data_valid, 0);
        tick();
        reset = 1'b0;
        idle();
        settle();
        check("post_rst_ins_rdata", ins_rdata, 0);
        check("post_rst_data_rdata", data_rdata, 0);
        check("idle_ins_wait", ins_wait, 0);
        check("idle_data_wait", data_wait, 0);

        // Instruction-only fetch.
        tick();
        ins_read = 1'b1;
        ins_addr = 10'h004;
        settle();
        check("if_mem_re", mem_re, 1);
        check("if_mem_addr", mem_addr, 10'h004);
        check("if_mem_be", mem_be, 4'b1111);
        check("if_ins_wait", ins_wait, 0);
        tick();
        ins_read  = 1'b0;
        mem_rdata = 32'h0050_0093;
        settle();
        check("if_ins_valid", ins_valid, 1);
        check("if_ins_rdata", ins_rdata, 32'h0050_0093);
        check("if_data_valid", data_valid, 0);
        check("if_ins_wait_c1", ins_wait, 0);
        tick();
        mem_rdata = 32'h1234_5678;
        settle();
        check("if_ins_valid_pulse", ins_valid, 0);
        check("if_ins_rdata_hold", ins_rdata, 32'h0050_0093);

        // Contended fetch and data read: data first, fetch next cycle.
        ins_read  = 1'b1;
        ins_addr  = 10'h010;
        data_rd   = 1'b1;
        data_addr = 10'h020;
        settle();
        check("ct_mem_addr0", mem_addr, 10'h020);
        check("ct_ins_wait0", ins_wait, 1);
        check("ct_data_wait0", data_wait, 0);
        tick();
        data_rd   = 1'b0;
        mem_rdata = 32'hAAAA_0020;
        settle();
        check("ct_mem_addr1", mem_addr, 10'h010);
        check("ct_mem_re1", mem_re, 1);
        check("ct_ins_wait1", ins_wait, 0);
        check("ct_data_valid1", data_valid, 1);
        check("ct_data_rdata1", data_rdata, 32'hAAAA_0020);
        check("ct_ins_valid1", ins_valid, 0);
        tick();
        ins_read  = 1'b0;
        mem_rdata = 32'hBBBB_0010;
        settle();
        check("ct_ins_valid2", ins_valid, 1);
        check("ct_ins_rdata2", ins_rdata, 32'hBBBB_0010);
        check("ct_data_valid2", data_valid, 0);
        check("ct_data_rdata2", data_rdata, 32'hAAAA_0020);
        tick();

        // Partial-byte write: no response.
        data_wr    = 1'b1;
        data_addr  = 10'h030;
        data_wdata = 32'hDEAD_BEEF;
        data_be    = 4'b0011;
        settle();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_re", mem_re, 0);
        check("wr_mem_be", mem_be, 4'b0011);
        check("wr_mem_addr", mem_addr, 10'h030);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_data_wait", data_wait, 0);
        tick();
        idle();
        settle();
        check("wr_data_valid", data_valid, 0);
        check("wr_mem_we_off", mem_we, 0);
        tick();

        // Read and write together: write first, read next cycle.
        data_rd    = 1'b1;
        data_wr    = 1'b1;
        data_addr  = 10'h040;
        data_wdata = 32'h1122_3344;
        data_be    = 4'b1111;
        settle();
        check("rw_mem_we0", mem_we, 1);
        check("rw_mem_re0", mem_re, 0);
        check("rw_data_wait0", data_wait, 1);
        tick();
        data_wr = 1'b0;
        settle();
        check("rw_mem_re1", mem_re, 1);
        check("rw_mem_we1", mem_we, 0);
        check("rw_data_wait1", data_wait, 0);
        check("rw_data_valid1", data_valid, 0);
        tick();
        data_rd   = 1'b0;
        mem_rdata = 32'h5566_7788;
        settle();
        check("rw_data_valid2", data_valid, 1);
        check("rw_data_rdata2", data_rdata, 32'h5566_7788);
        tick();

        // Data port hammering; fetch wins on the 5th contended cycle only with the guard.
        data_rd   = 1'b1;
        data_addr = 10'h050;
        ins_read  = 1'b1;
        ins_addr  = 10'h060;
        for (int i = 0; i < 8; i++) begin
            logic exp_win;
            exp_win = GUARD && (i == 4);
            settle();
            if (ins_read) begin
                check($sformatf("sv_ins_wait%0d", i), ins_wait, !exp_win);
                check($sformatf("sv_mem_addr%0d", i), mem_addr, exp_win ? 10'h060 : 10'h050);
                check($sformatf("sv_data_wait%0d", i), data_wait, exp_win);
            end
            tick();
            if (exp_win) begin
                ins_read = 1'b0;
            end
        end
        idle();
        tick();
        tick();

        // Reset raised the cycle after a data read is accepted.
        data_rd   = 1'b1;
        data_addr = 10'h070;
        settle();
        check("rf_mem_re", mem_re, 1);
        tick();
        data_rd   = 1'b0;
        reset     = 1'b1;
        mem_rdata = 32'h9999_9999;
        settle();
        check("rf_data_valid", data_valid, 0);
        check("rf_data_rdata", data_rdata, 0);
        check("rf_ins_wait", ins_wait, 1);
        check("rf_data_wait", data_wait, 1);
        tick();
        reset = 1'b0;
        settle();
        check("rf_data_valid_after", data_valid, 0);
        check("rf_data_rdata_after", data_rdata, 0);
        check("rf_mem_re_after", mem_re, 0);
        tick();
        settle();
        check("rf_data_valid_late", data_valid, 0);
        check("rf_ins_valid_late", ins_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
